// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a two-bank, byte-wide memory with a registered read port.
// Walks six march elements, compares each read one cycle later and reports/counts mismatches.
module mbist_march_ctrl #(
  parameter int N_ROWS = 1024,
  parameter int N_COLW = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             ce,
  output logic             we,
  output logic [9:0]       row_addr,
  output logic [9:0]       col_addr,
  output logic [1:0]       bank_addr,
  output logic [7:0]       data_gen,
  input  logic [7:0]       data_o,
  output logic             fault_valid,
  output logic [9:0]       fault_row,
  output logic [9:0]       fault_col,
  output logic [1:0]       fault_bank,
  output logic [7:0]       fault_syn,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int WW = (N_COLW > 1) ? $clog2(N_COLW) : 1;
  localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROWS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(N_COLW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       elem_q, elem_d;
  logic             phase_q, phase_d;
  logic             bank_q, bank_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WW-1:0]    word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             rd_vld_q;
  logic [9:0]       flt_row_q, flt_col_q;
  logic [1:0]       flt_bank_q;
  logic [7:0]       flt_syn_q;
  logic [7:0]       exp_q;
  logic [9:0]       dly_row_q, dly_col_q;
  logic [1:0]       dly_bank_q;

  logic       run, two_op, down, at_last, next_down;
  logic       is_rd, is_wr, mismatch;
  logic [7:0] exp_val, wr_val, syn;
  logic [2:0] elem_nx;

  always_comb begin
    run       = (state_q == S_RUN);
    two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_nx   = elem_q + 3'd1;
    next_down = (elem_nx == 3'd3) || (elem_nx == 3'd4);
    at_last   = down ? (!bank_q && row_q == '0 && word_q == '0)
                     : (bank_q && row_q == ROW_LAST && word_q == WORD_LAST);
    is_rd     = run && (elem_q != 3'd0) && !phase_q;
    is_wr     = run && ((elem_q == 3'd0) || phase_q);
    exp_val   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? 8'hFF : 8'h00;
    wr_val    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? 8'hFF : 8'h00;
    syn       = data_o ^ exp_q;
    mismatch  = rd_vld_q && (syn != 8'h00);

    state_d = state_q;
    elem_d  = elem_q;
    phase_d = phase_q;
    bank_d  = bank_q;
    row_d   = row_q;
    word_d  = word_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    if (mismatch && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          phase_d = 1'b0;
          bank_d  = 1'b0;
          row_d   = '0;
          word_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (at_last) begin
            if (elem_q == 3'd5) begin
              state_d = S_FLUSH;
            end else begin
              // Each element restarts at its own first address in its own direction.
              elem_d = elem_nx;
              bank_d = next_down;
              row_d  = next_down ? ROW_LAST : '0;
              word_d = next_down ? WORD_LAST : '0;
            end
          end else if (!down) begin
            if (word_q == WORD_LAST) begin
              word_d = '0;
              if (row_q == ROW_LAST) begin
                row_d  = '0;
                bank_d = ~bank_q;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            if (word_q == '0) begin
              word_d = WORD_LAST;
              if (row_q == '0) begin
                row_d  = ROW_LAST;
                bank_d = ~bank_q;
              end else begin
                row_d = row_q - 1'b1;
              end
            end else begin
              word_d = word_q - 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        pass_d  = (cnt_d == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      elem_q     <= '0;
      phase_q    <= 1'b0;
      bank_q     <= 1'b0;
      row_q      <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      flt_row_q  <= '0;
      flt_col_q  <= '0;
      flt_bank_q <= '0;
      flt_syn_q  <= '0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      phase_q  <= phase_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      rd_vld_q <= is_rd;
      if (mismatch) begin
        flt_row_q  <= dly_row_q;
        flt_col_q  <= dly_col_q;
        flt_bank_q <= dly_bank_q;
        flt_syn_q  <= syn;
      end
    end
  end

  // Compare stage: read address and expected background, aligned with data_o.
  always_ff @(posedge clk) begin
    exp_q      <= exp_val;
    dly_row_q  <= row_addr;
    dly_col_q  <= col_addr;
    dly_bank_q <= bank_addr;
  end

  assign busy        = run || (state_q == S_FLUSH);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign ce          = run;
  assign we          = is_wr;
  assign row_addr    = run ? 10'(row_q) : 10'd0;
  assign col_addr    = run ? 10'({word_q, 3'b000}) : 10'd0;
  assign bank_addr   = run ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign data_gen    = is_wr ? wr_val : 8'h00;
  assign fault_valid = mismatch;
  assign fault_row   = mismatch ? dly_row_q  : flt_row_q;
  assign fault_col   = mismatch ? dly_col_q  : flt_col_q;
  assign fault_bank  = mismatch ? dly_bank_q : flt_bank_q;
  assign fault_syn   = mismatch ? syn        : flt_syn_q;
  assign fault_cnt   = cnt_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl (N_ROWS=4, N_COLW=2): fault-free, stuck-at, sequence,
// mid-run reset and counter saturation on a second CNT_W=2 instance.
module tb_mbist_march_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic        busy, done, pass, ce, we, fault_valid;
  logic [9:0]  row_addr, col_addr, fault_row, fault_col;
  logic [1:0]  bank_addr, fault_bank;
  logic [7:0]  data_gen, data_o, fault_syn;
  logic [15:0] fault_cnt;

  logic        b_busy, b_done, b_pass, b_ce, b_we, b_fault_valid;
  logic [9:0]  b_row_addr, b_col_addr, b_fault_row, b_fault_col;
  logic [1:0]  b_bank_addr, b_fault_bank;
  logic [7:0]  b_data_gen, b_data_o, b_fault_syn;
  logic [1:0]  b_fault_cnt;

  mbist_march_ctrl #(.N_ROWS(4), .N_COLW(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .ce(ce), .we(we), .row_addr(row_addr), .col_addr(col_addr), .bank_addr(bank_addr),
    .data_gen(data_gen), .data_o(data_o), .fault_valid(fault_valid), .fault_row(fault_row),
    .fault_col(fault_col), .fault_bank(fault_bank), .fault_syn(fault_syn), .fault_cnt(fault_cnt));

  mbist_march_ctrl #(.N_ROWS(4), .N_COLW(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(b_busy), .done(b_done), .pass(b_pass),
    .ce(b_ce), .we(b_we), .row_addr(b_row_addr), .col_addr(b_col_addr), .bank_addr(b_bank_addr),
    .data_gen(b_data_gen), .data_o(b_data_o), .fault_valid(b_fault_valid), .fault_row(b_fault_row),
    .fault_col(b_fault_col), .fault_bank(b_fault_bank), .fault_syn(b_fault_syn), .fault_cnt(b_fault_cnt));

  // Memory models: word index = {bank1 select, row[1:0], col word}.
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [7:0] sa1_a [16];
  logic [7:0] sa0_a [16];
  logic [7:0] sa1_b [16];
  logic [3:0] idx_a, idx_b;
  assign idx_a = {bank_addr[1], row_addr[1:0], col_addr[3]};
  assign idx_b = {b_bank_addr[1], b_row_addr[1:0], b_col_addr[3]};

  always @(posedge clk) begin
    if (ce && we) mem_a[idx_a] <= data_gen;
    if (ce && !we) data_o <= (mem_a[idx_a] & ~sa0_a[idx_a]) | sa1_a[idx_a];
    if (b_ce && b_we) mem_b[idx_b] <= b_data_gen;
    if (b_ce && !b_we) b_data_o <= mem_b[idx_b] | sa1_b[idx_b];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int n_busy, n_done, n_rd, n_wr, n_flt_b, seq_err, done_k;
  logic pass_at_done;
  logic [15:0] cnt_at_done;
  logic [22:0] e3_first, e3_last;
  logic [9:0]  flt_k[$];
  logic [7:0]  flt_syn[$];
  logic [21:0] flt_addr[$];

  task automatic run_test(input bit poke_start);
    logic [21:0] prev_addr;
    n_busy = 0; n_done = 0; n_rd = 0; n_wr = 0; n_flt_b = 0; seq_err = 0; done_k = -1;
    pass_at_done = 1'bx; cnt_at_done = 'x; e3_first = '0; e3_last = '0; prev_addr = '0;
    flt_k.delete(); flt_syn.delete(); flt_addr.delete();
    start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (poke_start && k == 20) start = 1'b1;
      if (poke_start && k == 21) start = 1'b0;
      if (busy) n_busy++;
      if (ce && we) n_wr++;
      if (ce && !we) n_rd++;
      if (b_fault_valid) n_flt_b++;
      if (fault_valid) begin
        flt_k.push_back(10'(k));
        flt_syn.push_back(fault_syn);
        flt_addr.push_back({fault_bank, fault_row, fault_col});
      end
      if (k == 80)  e3_first = {bank_addr, row_addr, col_addr, we};
      if (k == 111) e3_last  = {bank_addr, row_addr, col_addr, we};
      if (k >= 16 && k < 144) begin
        if (k % 2 == 1) begin
          if (!we || {bank_addr, row_addr, col_addr} != prev_addr) seq_err++;
        end else if (we) seq_err++;
      end
      prev_addr = {bank_addr, row_addr, col_addr};
      if (done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          pass_at_done = pass;
          cnt_at_done = fault_cnt;
        end
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sa1_a[i] = 8'h00;
      sa0_a[i] = 8'h00;
      sa1_b[i] = (i >= 8) ? 8'hFF : 8'h00;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, pass, ce, we, fault_valid, fault_cnt}, 64'h0);
    chk("rst_addr", {row_addr, col_addr, bank_addr, data_gen}, 64'h0);
    chk("rst_flt", {fault_row, fault_col, fault_bank, fault_syn}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ctrl", {busy, done, ce, we, b_busy, b_fault_cnt}, 64'h0);

    // Fault-free run; second instance sees bank1 stuck at FF.
    run_test(1'b0);
    chk("t1_busy", n_busy, 161);
    chk("t1_done_k", done_k, 161);
    chk("t1_done_n", n_done, 1);
    chk("t1_pass", pass_at_done, 1'b1);
    chk("t1_cnt", cnt_at_done, 16'd0);
    chk("t1_reads", n_rd, 80);
    chk("t1_writes", n_wr, 80);
    chk("t1_faults", flt_k.size(), 0);
    chk("t4_e3_first", e3_first, {2'b10, 10'd3, 10'd8, 1'b0});
    chk("t4_e3_last", e3_last, {2'b01, 10'd0, 10'd0, 1'b1});
    chk("t4_rw_pairs", seq_err, 0);
    chk("t6_pulses", n_flt_b, 24);
    chk("t6_cnt_sat", b_fault_cnt, 2'd3);
    chk("t6_pass", b_pass, 1'b0);
    chk("t6_syn", b_fault_syn, 8'hFF);

    // Stuck-at-1, bank0 row2 col8 bit7.
    sa1_a[5] = 8'h80;
    run_test(1'b0);
    chk("t2_nflt", flt_k.size(), 3);
    chk("t2_times", {flt_k[0], flt_k[1], flt_k[2]}, {10'd27, 10'd101, 10'd150});
    chk("t2_syn", {flt_syn[0], flt_syn[1], flt_syn[2]}, 24'h808080);
    chk("t2_addr0", flt_addr[0], {2'b01, 10'd2, 10'd8});
    chk("t2_addr2", flt_addr[2], {2'b01, 10'd2, 10'd8});
    chk("t2_cnt", cnt_at_done, 16'd3);
    chk("t2_pass", pass_at_done, 1'b0);
    chk("t2_hold", {fault_bank, fault_row, fault_col, fault_syn}, {2'b01, 10'd2, 10'd8, 8'h80});

    // Stuck-at-0, bank1 row3 col0 bit0; counter restarts from zero.
    sa1_a[5] = 8'h00;
    sa0_a[14] = 8'h01;
    run_test(1'b0);
    chk("t3_nflt", flt_k.size(), 2);
    chk("t3_times", {flt_k[0], flt_k[1]}, {10'd77, 10'd115});
    chk("t3_syn", {flt_syn[0], flt_syn[1]}, 16'h0101);
    chk("t3_addr", flt_addr[1], {2'b10, 10'd3, 10'd0});
    chk("t3_cnt", cnt_at_done, 16'd2);
    chk("t3_pass", pass_at_done, 1'b0);

    // Reset in the middle of a run.
    sa0_a[14] = 8'h00;
    start = 1'b1;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    chk("t5_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", {busy, done, pass, ce, we, fault_valid, fault_cnt}, 64'h0);
    chk("t5_rst_addr", {row_addr, col_addr, bank_addr, data_gen}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || fault_valid) n_done++;
      if (busy || ce) n_busy++;
    end
    chk("t5_quiet", {n_done[15:0], n_busy[15:0]}, 32'h0);
    run_test(1'b1);
    chk("t5_busy", n_busy, 161);
    chk("t5_done_n", n_done, 1);
    chk("t5_reads", n_rd, 80);
    chk("t5_cnt", cnt_at_done, 16'd0);
    chk("t5_pass", pass_at_done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- memory BIST controller: the initiator for the two-bank, byte-wide test memory. After a `start` pulse it walks every word of both banks, drives the memory's `ce`/`we`/address/write-data port, and compares each registered read-back word against the expected background. Every mismatch is reported on a one-cycle fault port and counted. It sits inside the BIST top, between the test sequencer and the memory array.

## Interface
Parameters:
- `N_ROWS`, default 1024: rows per bank, tested 0..N_ROWS-1.
- `N_COLW`, default 128: 8-bit words per row; word k lives at `col_addr = 8*k`.
- `CNT_W`, default 16: width of the fault counter.

Ports:
- `clk`  in  1  system clock, 100 MHz; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts a test when idle.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a test.
- `pass`  out  1  valid from `done` until the next `start`; 1 when `fault_cnt == 0`.
- `ce`  out  1  memory chip enable.
- `we`  out  1  memory write enable; 1 = write, 0 = read.
- `row_addr`  out  10  memory row address.
- `col_addr`  out  10  memory column address; always a multiple of 8.
- `bank_addr`  out  2  one-hot bank select: `01` = bank0, `10` = bank1.
- `data_gen`  out  8  memory write data.
- `data_o`  in  8  memory read data, registered by the memory.
- `fault_valid`  out  1  one-cycle mismatch pulse.
- `fault_row`, `fault_col`, `fault_bank`  out  10/10/2  address of the failing read.
- `fault_syn`  out  8  syndrome: expected XOR read data.
- `fault_cnt`  out  CNT_W  mismatch count; saturates at all-ones.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: one memory operation per cycle.
  - FLUSH: one cycle to compare the final read.
  - DONE: pulses `done`, then returns to IDLE.
- Element sequence:
  - E0 ⇑(w00)
  - E1 ⇑(r00, wFF)
  - E2 ⇑(rFF, w00)
  - E3 ⇓(r00, wFF)
  - E4 ⇓(rFF, w00)
  - E5 ⇑(r00)
- Each element visits every word address.
  - ⇑ order: col word innermost, then row, then bank; from bank0 row0 word0 to bank1 row N_ROWS-1 word N_COLW-1.
  - ⇓ order is the exact reverse.
- Two-op elements issue the read, then the write to the same address, on consecutive cycles; then the address advances.
- Total words W = 2·N_ROWS·N_COLW. RUN lasts exactly 10·W cycles with no idle cycles inside or between elements.
- Compare pipeline:
  - A read issued in cycle t is compared in cycle t+1 against `data_o`.
  - The read's address and expected value are delayed one stage for the compare.
  - On a mismatch, `fault_valid` is asserted with that delayed address and the syndrome, and `fault_cnt` increments.
- `ce` is high only in RUN. In all other states `ce=0`, `we=0`, and the address and data outputs are 0.
- `start` while `busy` is ignored. A new `start` clears `fault_cnt` and `pass`.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-test: immediate return to IDLE, outputs 0. No partial `done` and no fault pulse after reset release.
- Start sequence:
  - `start` sampled high in IDLE at edge t: RUN begins in cycle t+1.
  - `busy=1`, `ce=1`, `we=1`, address = bank0/0/0.
- End sequence, with the last RUN cycle at index 10W-1:
  - FLUSH follows; it carries the E5 last compare and `busy=1`.
  - DONE is the next cycle: `done=1`, `pass` valid, `busy=0`.
  - IDLE follows.
- Fault pulse: `fault_valid` is high for exactly one cycle per mismatching read, one cycle after that read's issue cycle. Fault fields hold their value until the next fault.
- Address wrap in ⇑ order:
  - Col word N_COLW-1 → 0, and row increments.
  - Row N_ROWS-1 → 0, and bank `01` → `10`.
  - At bank1's last word the element increments and the address resets to its start: bank0/0/0 for ⇑, bank1 last word for ⇓.
- Counter saturation: at all-ones, further mismatches still pulse `fault_valid` but `fault_cnt` holds.

## Test plan
All scenarios use N_ROWS=4, N_COLW=2 (W=16) unless stated.
1. Fault-free memory model; pulse `start` → `busy` for 161 cycles; `done` pulses once; `pass=1`; `fault_cnt=0`; 80 reads and 80 writes observed.
2. Stuck-at-1 injected at bank0, row 2, col 8, bit 7 → faults at E1, E3, E5 reads of (row 2, col 8, bank `01`) with `fault_syn=80`, `fault_cnt=3`, `pass=0`.
3. Stuck-at-0 injected at bank1, row 3, col 0, bit 0 → faults at E2 and E4 reads with `fault_syn=01`, `fault_cnt=2`.
4. Check the E3 address sequence → first address is bank `10`/row 3/col 8, last is bank `01`/0/0; every write follows a read of the same address.
5. Deassert `rst_n` at RUN cycle 50, release it, then pulse `start` → all outputs 0 during reset; a fresh full run completes with correct counts; a `start` pulsed during RUN has no effect.
6. `CNT_W=2` with an all-bits-stuck bank → `fault_cnt` saturates at 3; `fault_valid` continues pulsing.
